spi_shift_register: RTL and testbench

Serialiser/deserialiser stage directly downstream of the SPI baud generator. Consumes its single-cycle MOSI-send and MISO-receive strobes, shifts a parallel transmit word out on MOSI, and assembles the MISO bits into a parallel receive word. It signals completion to the control/APB slave logic with a one-cycle strobe.

---
 rtl/spi_shift_register.sv | 176 +++++++++++++++++
 tb/tb_spi_shift_register.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_register.sv
// spi_shift_register
// Serialiser/deserialiser stage sitting behind the SPI baud generator.
// A parallel word is loaded on send_data_i. Once slave select is low, the
// word is shifted out on mosi_o, one bit per transmit strobe. MISO bits are
// captured into a receive word, one bit per receive strobe. When the last
// receive bit lands, the word is published on data_miso_o and
// receive_data_o pulses for one cycle.
//
// Ports
//   PCLK, PRESET          clock; synchronous active-high reset
//   ss_i                  slave select (active low); high aborts a transfer
//   send_data_i           one-cycle load request for data_mosi_i
//   data_mosi_i           word to transmit
//   lsbfe_i               1 = LSB first; sampled only at load
//   cpol_i, cpha_i        SPI mode; selects which strobe pair is live
//   mosi_send_sclk_i      transmit strobe when cpol_i == cpha_i
//   mosi_send_sclk0_i     transmit strobe when cpol_i != cpha_i
//   miso_receive_sclk_i   receive strobe when cpol_i == cpha_i
//   miso_receive_sclk0_i  receive strobe when cpol_i != cpha_i
//   miso_i                serial input line
//   mosi_o                serial output line
//   data_miso_o           last completed received word
//   busy_o                high from load until completion or abort
//   receive_data_o        one-cycle strobe when data_miso_o updates
module spi_shift_register #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  ss_i,
  input  logic                  send_data_i,
  input  logic [DATA_WIDTH-1:0] data_mosi_i,
  input  logic                  lsbfe_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  mosi_send_sclk_i,
  input  logic                  mosi_send_sclk0_i,
  input  logic                  miso_receive_sclk_i,
  input  logic                  miso_receive_sclk0_i,
  input  logic                  miso_i,
  output logic                  mosi_o,
  output logic [DATA_WIDTH-1:0] data_miso_o,
  output logic                  busy_o,
  output logic                  receive_data_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1);  // counter width, holds DATA_WIDTH
  localparam int IW = $clog2(DATA_WIDTH);      // bit index width
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] IDX_TOP  = IW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOADED, SHIFT} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] tx_reg, tx_next;
  logic [DATA_WIDTH-1:0] rx_reg, rx_next;
  logic [DATA_WIDTH-1:0] data_miso_reg, data_miso_next;
  logic [CW-1:0]         tx_cnt_reg, tx_cnt_next;
  logic [CW-1:0]         rx_cnt_reg, rx_cnt_next;
  logic                  lsb_reg, lsb_next;
  logic                  mosi_reg, mosi_next;
  logic                  busy_reg, busy_next;
  logic                  rcv_reg, rcv_next;

  logic                  tx_stb, rx_stb;
  logic                  tx_fire, rx_fire;
  logic [IW-1:0]         tx_idx, rx_idx;
  logic [DATA_WIDTH-1:0] rx_merged;

  // Only one strobe pair is meaningful for a given mode; the other is ignored.
  assign tx_stb = (cpol_i ^ cpha_i) ? mosi_send_sclk0_i    : mosi_send_sclk_i;
  assign rx_stb = (cpol_i ^ cpha_i) ? miso_receive_sclk0_i : miso_receive_sclk_i;

  // A strobe acts only while shifting with slave select low (so an abort wins)
  // and only until its counter saturates at DATA_WIDTH.
  assign tx_fire = (state_reg == SHIFT) && !ss_i && tx_stb && (tx_cnt_reg < CNT_FULL);
  assign rx_fire = (state_reg == SHIFT) && !ss_i && rx_stb && (rx_cnt_reg < CNT_FULL);

  // Counter-to-bit mapping. The low IW bits suffice whenever the counter is
  // below DATA_WIDTH, which is the only time the index is used.
  assign tx_idx = lsb_reg ? tx_cnt_reg[IW-1:0] : IDX_TOP - tx_cnt_reg[IW-1:0];
  assign rx_idx = lsb_reg ? rx_cnt_reg[IW-1:0] : IDX_TOP - rx_cnt_reg[IW-1:0];

  // Receive word with this cycle's MISO bit merged in. Completion publishes it
  // directly, so the final bit appears in data_miso_o on the same edge.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rx_bit
    assign rx_merged[gi] = (rx_fire && (rx_idx == IW'(gi))) ? miso_i : rx_reg[gi];
  end

  always_comb begin
    state_next     = state_reg;
    tx_next        = tx_reg;
    rx_next        = rx_reg;
    data_miso_next = data_miso_reg;
    tx_cnt_next    = tx_cnt_reg;
    rx_cnt_next    = rx_cnt_reg;
    lsb_next       = lsb_reg;
    mosi_next      = mosi_reg;
    busy_next      = busy_reg;
    rcv_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (send_data_i) begin
          tx_next     = data_mosi_i;
          rx_next     = '0;
          lsb_next    = lsbfe_i;
          tx_cnt_next = '0;
          rx_cnt_next = '0;
          busy_next   = 1'b1;
          state_next  = LOADED;
        end
      end
      LOADED: begin
        if (!ss_i) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_i) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          if (tx_fire) begin
            mosi_next   = tx_reg[tx_idx];
            tx_cnt_next = tx_cnt_reg + CW'(1);
          end
          if (rx_fire) begin
            rx_next     = rx_merged;
            rx_cnt_next = rx_cnt_reg + CW'(1);
            if (rx_cnt_reg == CNT_LAST) begin
              data_miso_next = rx_merged;
              rcv_next       = 1'b1;
              busy_next      = 1'b0;
              state_next     = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg     <= IDLE;
      tx_reg        <= '0;
      rx_reg        <= '0;
      data_miso_reg <= '0;
      tx_cnt_reg    <= '0;
      rx_cnt_reg    <= '0;
      lsb_reg       <= 1'b0;
      mosi_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      rcv_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tx_reg        <= tx_next;
      rx_reg        <= rx_next;
      data_miso_reg <= data_miso_next;
      tx_cnt_reg    <= tx_cnt_next;
      rx_cnt_reg    <= rx_cnt_next;
      lsb_reg       <= lsb_next;
      mosi_reg      <= mosi_next;
      busy_reg      <= busy_next;
      rcv_reg       <= rcv_next;
    end
  end

  assign mosi_o         = mosi_reg;
  assign data_miso_o    = data_miso_reg;
  assign busy_o         = busy_reg;
  assign receive_data_o = rcv_reg;

endmodule

// File: tb/tb_spi_shift_register.sv
// Testbench for spi_shift_register.
// Directed scenarios plus randomised transfers are checked against a
// bit-order model kept here. The model derives each MOSI bit and the
// assembled MISO word arithmetically from the word, the bit order and the
// slave's bit stream.
module tb_spi_shift_register;
  localparam int DW = 8;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          ss_i;
  logic          send_data_i;
  logic [DW-1:0] data_mosi_i;
  logic          lsbfe_i;
  logic          cpol_i;
  logic          cpha_i;
  logic          mosi_send_sclk_i;
  logic          mosi_send_sclk0_i;
  logic          miso_receive_sclk_i;
  logic          miso_receive_sclk0_i;
  logic          miso_i;
  logic          mosi_o;
  logic [DW-1:0] data_miso_o;
  logic          busy_o;
  logic          receive_data_o;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] last_rx;

  always #5 PCLK = ~PCLK;

  spi_shift_register #(.DATA_WIDTH(DW)) dut (
    .PCLK                 (PCLK),
    .PRESET               (PRESET),
    .ss_i                 (ss_i),
    .send_data_i          (send_data_i),
    .data_mosi_i          (data_mosi_i),
    .lsbfe_i              (lsbfe_i),
    .cpol_i               (cpol_i),
    .cpha_i               (cpha_i),
    .mosi_send_sclk_i     (mosi_send_sclk_i),
    .mosi_send_sclk0_i    (mosi_send_sclk0_i),
    .miso_receive_sclk_i  (miso_receive_sclk_i),
    .miso_receive_sclk0_i (miso_receive_sclk0_i),
    .miso_i               (miso_i),
    .mosi_o               (mosi_o),
    .data_miso_o          (data_miso_o),
    .busy_o               (busy_o),
    .receive_data_o       (receive_data_o)
  );

  // Advance one clock; outputs are read 1 time unit after the edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the mode-selected strobe pair; the unused pair gets random noise.
  task automatic drive_strobes(input logic tx, input logic rx);
    if (cpol_i ^ cpha_i) begin
      mosi_send_sclk0_i    = tx;
      miso_receive_sclk0_i = rx;
      mosi_send_sclk_i     = 1'($urandom_range(0, 1));
      miso_receive_sclk_i  = 1'($urandom_range(0, 1));
    end else begin
      mosi_send_sclk_i     = tx;
      miso_receive_sclk_i  = rx;
      mosi_send_sclk0_i    = 1'($urandom_range(0, 1));
      miso_receive_sclk0_i = 1'($urandom_range(0, 1));
    end
  endtask

  // Model: k-th bit on the wire for a given word and bit order.
  function automatic logic wire_bit(input logic [DW-1:0] word, input logic lsbfe, input int k);
    if (lsbfe) return 1'((word >> k) & 1);
    return 1'((word >> (DW - 1 - k)) & 1);
  endfunction

  // Load a word, wait in LOADED with ss high (strobes must be ignored), then
  // drop ss so the next cycle starts shifting.
  task automatic load_word(input logic [DW-1:0] word, input logic lsbfe, input string name);
    logic prev;
    ss_i = 1'b1; send_data_i = 1'b1; data_mosi_i = word; lsbfe_i = lsbfe;
    drive_strobes(1'b0, 1'b0);
    tick();
    send_data_i = 1'b0;
    data_mosi_i = DW'($urandom);
    lsbfe_i     = 1'($urandom_range(0, 1));
    check({name, "_busy_load"}, busy_o, 1);
    prev = mosi_o;
    drive_strobes(1'b1, 1'b1);
    tick();
    ss_i = 1'b0;
    drive_strobes(1'b1, 1'b1);
    tick();
    check({name, "_loaded_ignores"}, mosi_o, prev);
  endtask

  task automatic run_transfer(input logic [DW-1:0] word, input logic lsbfe,
                              input logic cpol, input logic cpha,
                              input logic [DW-1:0] miso_seq, input bit coin,
                              input bit extra, input bit intrude, input bit late,
                              input string name);
    logic [DW-1:0] exp_rx;
    logic          b, m;
    int            gaps;
    cpol_i = cpol; cpha_i = cpha;
    load_word(word, lsbfe, name);
    exp_rx = '0;
    for (int k = 0; k < DW; k++) begin
      b = wire_bit(word, lsbfe, k);
      m = 1'((miso_seq >> (DW - 1 - k)) & 1);
      exp_rx = lsbfe ? (exp_rx | (DW'(m) << k)) : ((exp_rx << 1) | DW'(m));
      if (intrude && k == 3) begin send_data_i = 1'b1; data_mosi_i = '1; end
      if (late && k == DW - 1) send_data_i = 1'b1;
      if (coin && !(extra && k == DW - 1)) begin
        miso_i = m;
        drive_strobes(1'b1, 1'b1);
        tick();
        send_data_i = 1'b0;
        check($sformatf("%s_mosi%0d", name, k), mosi_o, b);
      end else begin
        miso_i = 1'($urandom_range(0, 1));
        drive_strobes(1'b1, 1'b0);
        tick();
        if (!(late && k == DW - 1)) send_data_i = 1'b0;
        check($sformatf("%s_mosi%0d", name, k), mosi_o, b);
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) begin
          miso_i = 1'($urandom_range(0, 1));
          drive_strobes(1'b0, 1'b0);
          tick();
        end
        if (gaps > 0) check($sformatf("%s_hold%0d", name, k), mosi_o, b);
        if (extra && k == DW - 1) begin
          drive_strobes(1'b1, 1'b0);
          tick();
          check({name, "_extra_tx"}, mosi_o, b);
        end
        miso_i = m;
        drive_strobes(1'b0, 1'b1);
        tick();
        send_data_i = 1'b0;
      end
      if (k < DW - 1) begin
        check($sformatf("%s_busy%0d", name, k), busy_o, 1);
        check($sformatf("%s_norcv%0d", name, k), receive_data_o, 0);
      end else begin
        check({name, "_rcv"}, receive_data_o, 1);
        check({name, "_word"}, data_miso_o, exp_rx);
        check({name, "_idle"}, busy_o, 0);
      end
    end
    drive_strobes(1'b0, 1'b0);
    tick();
    check({name, "_rcv_once"}, receive_data_o, 0);
    if (late) check({name, "_late_send"}, busy_o, 0);
    last_rx = exp_rx;
    $display("xfer %s tx=%h lsbfe=%0d mode=%0d rx=%h", name, word, lsbfe, {cpol, cpha}, exp_rx);
  endtask

  // Shift a few bits with separate tx/rx strobes (no completion).
  task automatic partial_bits(input int n);
    for (int k = 0; k < n; k++) begin
      drive_strobes(1'b1, 1'b0);
      tick();
      miso_i = 1'($urandom_range(0, 1));
      drive_strobes(1'b0, 1'b1);
      tick();
    end
    drive_strobes(1'b0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] w;
    PRESET = 1'b1; ss_i = 1'b1; send_data_i = 1'b0; data_mosi_i = '0;
    lsbfe_i = 1'b0; cpol_i = 1'b0; cpha_i = 1'b0; miso_i = 1'b0;
    mosi_send_sclk_i = 1'b0; mosi_send_sclk0_i = 1'b0;
    miso_receive_sclk_i = 1'b0; miso_receive_sclk0_i = 1'b0;
    tick();
    tick();
    check("rst_mosi", mosi_o, 0);
    check("rst_data", data_miso_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rcv", receive_data_o, 0);
    PRESET = 1'b0;
    tick();

    // Mode 0, MSB first
    run_transfer(8'hA5, 1'b0, 1'b0, 1'b0, 8'b1100_1010, 0, 0, 0, 0, "t1");
    check("t1_const", data_miso_o, 8'hCA);

    // Abort after 4 bits; a coincident strobe must lose to the abort
    cpol_i = 1'b0; cpha_i = 1'b0;
    w = 8'h93;
    load_word(w, 1'b0, "abort");
    partial_bits(4);
    ss_i = 1'b1;
    drive_strobes(1'b1, 1'b1);
    tick();
    check("abort_busy", busy_o, 0);
    check("abort_rcv", receive_data_o, 0);
    check("abort_data", data_miso_o, last_rx);
    check("abort_mosi", mosi_o, wire_bit(w, 1'b0, 3));
    drive_strobes(1'b0, 1'b0);
    tick();
    check("abort_rcv2", receive_data_o, 0);
    $display("xfer abort tx=%h after 4 bits", w);

    // Mode 1, LSB first, unused strobe pair toggling
    run_transfer(8'h3C, 1'b1, 1'b0, 1'b1, DW'($urandom), 0, 0, 0, 0, "t2");

    // New load request while busy is ignored
    run_transfer(8'h81, 1'b0, 1'b0, 1'b0, DW'($urandom), 0, 0, 1, 0, "t4");

    // Reset mid-shift
    cpol_i = 1'b0; cpha_i = 1'b0;
    load_word(8'hFF, 1'b0, "rstmid");
    partial_bits(3);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    check("rstmid_mosi", mosi_o, 0);
    check("rstmid_data", data_miso_o, 0);
    check("rstmid_busy", busy_o, 0);
    check("rstmid_rcv", receive_data_o, 0);
    last_rx = '0;
    $display("xfer reset mid-shift");
    tick();
    run_transfer(8'h5A, 1'b0, 1'b0, 1'b0, DW'($urandom), 0, 0, 0, 0, "t5");

    // Coincident strobes plus a surplus 9th tx strobe
    run_transfer(8'hB7, 1'b0, 1'b0, 1'b0, DW'($urandom), 1, 1, 0, 0, "t6");

    // Randomised transfers across all modes
    for (int i = 0; i < 8; i++) begin
      run_transfer(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
